led_band_sequencer: RTL and testbench
=====================================

# led_band_sequencer

Generates the serial timing for one LED band: the `SCLK`, `LAT`, `angle`, `row`, `color` and `bit_sel` inputs of `led_band_controller`, plus its `new_frame` buffer-swap pulse. On each angular tick from the rotation sensor it advances the angle and shifts every bit plane of that angle into the drivers. It sits directly upstream of `led_band_controller`, and one instance drives all bands in lockstep.

## Interface
- `NB_LED_COLUMN`, 32, LEDs per band (rows)
- `BIT_PER_COLOR`, 8, grayscale bits per color
- `NB_0_LSB`, 1, extra all-zero LSB planes
- `NB_ANGLES`, 128, angular positions per revolution
- `SCLK_DIV`, 2, clk cycles per `SCLK` half-period (≥2)
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `run`  in  1  enable; low blocks new angle starts (driver not configured)
- `angle_tick`  in  1  one-cycle pulse: advance to next angle
- `swap_req`  in  1  one-cycle pulse: writer finished filling back buffer
- `SCLK`  out  1  driver shift clock
- `LAT`  out  1  driver latch
- `angle`  out  $clog2(NB_ANGLES)  angle being shifted
- `row`  out  $clog2(NB_LED_COLUMN)  current row
- `color`  out  2  current color (0..2)
- `bit_sel`  out  $clog2(BIT_PER_COLOR+NB_0_LSB)  current plane
- `new_frame`  out  1  one-cycle buffer-swap pulse
- `busy`  out  1  shifting in progress
- `overrun`  out  1  sticky: tick dropped

## Operation
- Reset values: `SCLK`=0, `LAT`=0, `angle`=NB_ANGLES-1, `row`=NB_LED_COLUMN-1, `color`=2, `bit_sel`=0, `new_frame`=0, `busy`=0, `overrun`=0, swap-pending=0, tick-pending=0.
- States: IDLE, START, LOW, HIGH.
- IDLE -> START when tick-pending or `angle_tick`, and `run`=1. Consumes the tick.
- START (1 cycle):
  - `angle` <= (angle+1) mod NB_ANGLES.
  - Counters load `bit_sel`=0, `row`=NB_LED_COLUMN-1, `color`=2.
  - If the new angle is 0 and swap-pending, `new_frame`=1 this cycle and swap-pending clears.
  - Then LOW.
- LOW: `SCLK`=0 for SCLK_DIV cycles, then HIGH.
- HIGH: `SCLK`=1 for SCLK_DIV cycles. On exit the counters step in this order:
  - `color` decrements; at 0 it wraps to 2 and `row` decrements.
  - `row` wraps from 0 to NB_LED_COLUMN-1 and `bit_sel` increments.
  - After the last bit (`bit_sel`=BIT_PER_COLOR+NB_0_LSB-1, `row`=0, `color`=0) go to IDLE; otherwise go to LOW.
- Shift count per angle: (BIT_PER_COLOR+NB_0_LSB)·NB_LED_COLUMN·3. Defaults give 864 `SCLK` pulses.
- `LAT` goes high at the start of LOW and falls at the end of HIGH for these pulses:
  - the last pulse of each non-final plane (write-GS latch, 1 SCLK wide);
  - the last 3 pulses of the final plane (latch-GS, 3 SCLK wide).
- `busy`=1 in START, LOW and HIGH.
- Tick arriving while `busy` or while `run`=0: sets tick-pending.
  - If tick-pending is already set, the tick is dropped and `overrun` sets.
  - `overrun` clears only on reset.
- `swap_req` at any time sets swap-pending. Repeated requests merge.
- `swap_req` in the same cycle as the START that clears swap-pending: the request stays pending for the next wrap.
- `run` falling mid-angle: the current angle completes. No new START until `run`=1.
- Asynchronous reset mid-shift: all outputs return to reset values immediately. No partial `LAT` pulse is emitted after release.

## Timing
- `row`, `color` and `bit_sel` change only on the LOW entry edge. They are stable for SCLK_DIV cycles before `SCLK` rises, which covers the controller's 1-cycle memory read latency.
- `angle_tick` in IDLE with `run`=1: START is the next cycle, and `SCLK` first rises SCLK_DIV+1 cycles after START.
- Angle duration: 1 + 864·2·SCLK_DIV cycles. Defaults give 3457 cycles.
- Back-to-back: with tick-pending set, START follows the final HIGH exit with 1 IDLE cycle.
- `new_frame` coincides with START of angle 0. `angle` shows 0 from the following cycle.

## Test plan
- Reset released, `run`=1, single `angle_tick`:
  - `angle`=0 and 864 `SCLK` pulses;
  - `busy` high for 3457 cycles;
  - first fields `row`=31, `color`=2, `bit_sel`=0; last fields 0/0/8.
- Monitor `LAT` over one angle:
  - 8 one-pulse-wide latches at the ends of planes 0..7;
  - one latch 3 pulses wide ending on pulse 864.
- `swap_req` at angle 50, ticks continue:
  - exactly one `new_frame` pulse, at START of angle 0;
  - none at the next wrap unless `swap_req` is asserted again.
- Two extra ticks during a shift:
  - the first is pending and starts 1 cycle after completion;
  - the second sets `overrun`=1, which stays set.
- `run`=0 then `angle_tick`: no `SCLK`. Raising `run` starts the pending angle.
- `rst` asserted mid-HIGH with `LAT`=1:
  - `SCLK`=0, `LAT`=0, `angle`=127 asynchronously;
  - the next tick yields `angle`=0.

Source files
------------

// File: rtl/led_band_sequencer.sv
// Serial timing generator for one LED band: per angular tick, shifts every bit
// plane of the next angle into the drivers with SCLK/LAT and field counters.
module led_band_sequencer #(
    parameter int NB_LED_COLUMN = 32,
    parameter int BIT_PER_COLOR = 8,
    parameter int NB_0_LSB      = 1,
    parameter int NB_ANGLES     = 128,
    parameter int SCLK_DIV      = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       run,
    input  logic                                       angle_tick,
    input  logic                                       swap_req,
    output logic                                       SCLK,
    output logic                                       LAT,
    output logic [$clog2(NB_ANGLES)-1:0]               angle,
    output logic [$clog2(NB_LED_COLUMN)-1:0]           row,
    output logic [1:0]                                 color,
    output logic [$clog2(BIT_PER_COLOR+NB_0_LSB)-1:0]  bit_sel,
    output logic                                       new_frame,
    output logic                                       busy,
    output logic                                       overrun
);

    localparam int ANG_W = $clog2(NB_ANGLES);
    localparam int ROW_W = $clog2(NB_LED_COLUMN);
    localparam int BIT_W = $clog2(BIT_PER_COLOR + NB_0_LSB);
    localparam int DIV_W = $clog2(SCLK_DIV);

    localparam logic [ANG_W-1:0] ANG_LAST = ANG_W'(NB_ANGLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NB_LED_COLUMN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_PER_COLOR + NB_0_LSB - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, LOW, HIGH} state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [ANG_W-1:0] angle_inc;
    logic             div_done;
    logic             last_bit;
    logic             lat_sel;
    logic             tick_pending;
    logic             swap_pending;

    assign div_done  = (div_cnt == DIV_LAST);
    assign angle_inc = (angle == ANG_LAST) ? '0 : angle + 1'b1;
    assign last_bit  = (bit_sel == BIT_LAST) && (row == '0) && (color == 2'd0);
    // Last field of a plane latches; the final plane latches its last three fields
    assign lat_sel   = (row == '0) && ((bit_sel == BIT_LAST) || (color == 2'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        SCLK       = 1'b0;
        LAT        = 1'b0;
        busy       = 1'b1;
        new_frame  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (run && (tick_pending || angle_tick)) state_next = START;
            end
            START: begin
                new_frame  = swap_pending && (angle_inc == '0);
                state_next = LOW;
            end
            LOW: begin
                LAT = lat_sel;
                if (div_done) state_next = HIGH;
            end
            HIGH: begin
                SCLK = 1'b1;
                LAT  = lat_sel;
                if (div_done) state_next = last_bit ? IDLE : LOW;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            div_cnt <= '0;
        else if ((state == LOW || state == HIGH) && !div_done)
            div_cnt <= div_cnt + 1'b1;
        else
            div_cnt <= '0;
    end

    // Fields move only on the LOW entry edge (end of START or end of a HIGH)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row     <= ROW_LAST;
            color   <= 2'd2;
            bit_sel <= '0;
        end else if (state == START) begin
            row     <= ROW_LAST;
            color   <= 2'd2;
            bit_sel <= '0;
        end else if (state == HIGH && div_done && !last_bit) begin
            if (color != 2'd0) begin
                color <= color - 2'd1;
            end else begin
                color <= 2'd2;
                if (row != '0) begin
                    row <= row - 1'b1;
                end else begin
                    row     <= ROW_LAST;
                    bit_sel <= bit_sel + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                angle <= ANG_LAST;
        else if (state == START) angle <= angle_inc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_pending <= 1'b0;
            swap_pending <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            swap_pending <= swap_req || (swap_pending && !new_frame);
            if (state == IDLE && run) begin
                // A pending tick is consumed first; a simultaneous new tick waits
                tick_pending <= tick_pending && angle_tick;
            end else if (angle_tick) begin
                if (tick_pending) overrun      <= 1'b1;
                else              tick_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_band_sequencer.sv
// Bench for led_band_sequencer: a full-size instance for the default timing and
// a reduced instance checked cycle by cycle against an angle-level model.
module tb_led_band_sequencer;

    localparam int NC     = 4;
    localparam int BPC    = 2;
    localparam int NZ     = 1;
    localparam int NA     = 8;
    localparam int DIV    = 2;
    localparam int PLANES = BPC + NZ;
    localparam int PULSES = PLANES * NC * 3;
    localparam int LEN    = 1 + PULSES * 2 * DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    logic       run = 1'b0, angle_tick = 1'b0, swap_req = 1'b0;
    logic       sclk, lat, new_frame, busy, overrun;
    logic [2:0] angle;
    logic [1:0] row, color, bit_sel;

    logic       d_run = 1'b0, d_tick = 1'b0, d_swap = 1'b0;
    logic       d_sclk, d_lat, d_nf, d_busy, d_ovr;
    logic [6:0] d_angle;
    logic [4:0] d_row;
    logic [1:0] d_color;
    logic [3:0] d_bit;

    led_band_sequencer #(
        .NB_LED_COLUMN(NC), .BIT_PER_COLOR(BPC), .NB_0_LSB(NZ),
        .NB_ANGLES(NA), .SCLK_DIV(DIV)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .angle_tick(angle_tick), .swap_req(swap_req),
        .SCLK(sclk), .LAT(lat), .angle(angle), .row(row), .color(color),
        .bit_sel(bit_sel), .new_frame(new_frame), .busy(busy), .overrun(overrun)
    );

    led_band_sequencer dut_full (
        .clk(clk), .rst(rst), .run(d_run), .angle_tick(d_tick), .swap_req(d_swap),
        .SCLK(d_sclk), .LAT(d_lat), .angle(d_angle), .row(d_row), .color(d_color),
        .bit_sel(d_bit), .new_frame(d_nf), .busy(d_busy), .overrun(d_ovr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Angle-level model: rem = busy cycles left in the current angle (LEN at START)
    bit model_on = 1'b0;
    int rem, m_angle;
    bit m_pend, m_ovr, m_swap, m_nf;

    always @(posedge clk) begin
        if (!model_on || !rst) begin
            rem <= 0; m_angle <= NA - 1; m_pend <= 1'b0;
            m_ovr <= 1'b0; m_swap <= 1'b0; m_nf <= 1'b0;
        end else begin : step
            int r, a;
            bit pd, ov, sw;
            r = rem; a = m_angle; pd = m_pend; ov = m_ovr; sw = m_swap;
            if (r == LEN) a = (a + 1) % NA;
            sw = swap_req | (sw & ~m_nf);
            if (r == 0 && run) begin
                if (pd || angle_tick) r = LEN;
                pd = pd && angle_tick;
            end else begin
                if (r > 0) r--;
                if (angle_tick) begin
                    if (pd) ov = 1'b1;
                    else    pd = 1'b1;
                end
            end
            rem <= r; m_angle <= a; m_pend <= pd; m_ovr <= ov; m_swap <= sw;
            m_nf <= (r == LEN) && ((a + 1) % NA == 0) && sw;
        end
    end

    always @(negedge clk) begin
        if (model_on && rst) begin : cmp
            int t, k, ph, pl, w;
            chk("busy", busy, rem > 0);
            chk("angle", angle, m_angle);
            chk("new_frame", new_frame, m_nf);
            chk("overrun", overrun, m_ovr);
            if (rem == 0 || rem == LEN) begin
                chk("sclk_quiet", sclk, 0);
                chk("lat_quiet", lat, 0);
            end else begin
                t  = LEN - rem - 1;
                k  = t / (2 * DIV);
                ph = t % (2 * DIV);
                pl = k / (NC * 3);
                w  = k % (NC * 3);
                chk("sclk", sclk, ph >= DIV);
                chk("row", row, NC - 1 - w / 3);
                chk("color", color, 2 - w % 3);
                chk("bit_sel", bit_sel, pl);
                chk("lat", lat, (pl < PLANES - 1) ? (w == NC * 3 - 1) : (w >= NC * 3 - 3));
            end
        end
    end

    int nf_cnt = 0;
    always @(negedge clk) if (new_frame) nf_cnt++;

    typedef struct {
        bit rst_n, run, tick, swap;
        bit busy, sclk, lat, nf, ovr;
        int angle, row, color, bit_sel;
    } vec_t;
    vec_t tbl[10];

    task automatic tick_pulse();
        @(negedge clk) angle_tick = 1'b1;
        @(negedge clk) angle_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < LEN + 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic start_angle();
        tick_pulse();
        wait_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; model_on = 1'b0;
        run = 1'b0; angle_tick = 1'b0; swap_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; model_on = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cyc, pulses, lat_n, cur_w, last_end, nfd, gap, sc, found;
        int f_row, f_col, f_bit, l_row, l_col, l_bit;
        int lat_w[16];
        bit ps, pl, seen;

        // rst, run, tick, swap | busy, sclk, lat, nf, ovr | angle, row, color, bit_sel
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 3, 2, 0};
        tbl[1] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 7, 3, 2, 0};
        tbl[2] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 3, 2, 0};
        tbl[3] = '{1, 1, 0, 1, 1, 0, 0, 1, 0, 7, 3, 2, 0};
        tbl[4] = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 3, 2, 0};
        tbl[5] = '{1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 3, 2, 0};
        tbl[6] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 3, 2, 0};
        tbl[7] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 3, 2, 0};
        tbl[8] = '{1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 3, 1, 0};
        tbl[9] = '{1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 3, 1, 0};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst_n; run = tbl[i].run;
            angle_tick = tbl[i].tick; swap_req = tbl[i].swap;
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("vec%0d_sclk", i), sclk, tbl[i].sclk);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_nf", i), new_frame, tbl[i].nf);
            chk($sformatf("vec%0d_ovr", i), overrun, tbl[i].ovr);
            chk($sformatf("vec%0d_angle", i), angle, tbl[i].angle);
            chk($sformatf("vec%0d_row", i), row, tbl[i].row);
            chk($sformatf("vec%0d_color", i), color, tbl[i].color);
            chk($sformatf("vec%0d_bit", i), bit_sel, tbl[i].bit_sel);
        end
        run = 1'b0; angle_tick = 1'b0; swap_req = 1'b0;

        // Full-size instance: one angle with default parameters
        busy_cyc = 0; pulses = 0; lat_n = 0; cur_w = 0; last_end = 0; nfd = 0;
        f_row = -1; f_col = -1; f_bit = -1; l_row = -1; l_col = -1; l_bit = -1;
        ps = 1'b0; pl = 1'b0; seen = 1'b0;
        @(negedge clk) begin d_run = 1'b1; d_tick = 1'b1; end
        @(negedge clk) d_tick = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (d_busy) begin busy_cyc++; seen = 1'b1; end
            if (d_nf) nfd++;
            if (d_sclk && !ps) begin
                pulses++;
                if (pulses == 1) begin f_row = d_row; f_col = d_color; f_bit = d_bit; end
                l_row = d_row; l_col = d_color; l_bit = d_bit;
                if (d_lat) cur_w++;
            end
            if (!d_lat && pl) begin
                if (lat_n < 16) lat_w[lat_n] = cur_w;
                lat_n++; last_end = pulses; cur_w = 0;
            end
            ps = d_sclk; pl = d_lat;
            if (seen && !d_busy) break;
            @(negedge clk);
        end
        chk("full_done", d_busy, 0);
        chk("full_angle", d_angle, 0);
        chk("full_pulses", pulses, 864);
        chk("full_busy_cycles", busy_cyc, 3457);
        chk("full_first_row", f_row, 31);
        chk("full_first_color", f_col, 2);
        chk("full_first_bit", f_bit, 0);
        chk("full_last_row", l_row, 0);
        chk("full_last_color", l_col, 0);
        chk("full_last_bit", l_bit, 8);
        chk("full_lat_count", lat_n, 9);
        for (int i = 0; i < 8; i++) chk($sformatf("full_lat_w%0d", i), lat_w[i], 1);
        chk("full_lat_w8", lat_w[8], 3);
        chk("full_lat_end", last_end, 864);
        chk("full_nf", nfd, 0);
        chk("full_ovr", d_ovr, 0);

        // Swap request mid-revolution gives one new_frame at the next wrap only
        do_reset();
        run = 1'b1;
        repeat (6) start_angle();
        chk("angle_before_swap", angle, 5);
        @(negedge clk) swap_req = 1'b1;
        @(negedge clk) swap_req = 1'b0;
        nf_cnt = 0;
        repeat (3) start_angle();
        chk("nf_first_wrap", nf_cnt, 1);
        repeat (8) start_angle();
        chk("nf_second_wrap", nf_cnt, 1);

        // Two extra ticks during a shift
        tick_pulse();
        repeat (20) @(negedge clk);
        tick_pulse();
        repeat (20) @(negedge clk);
        tick_pulse();
        chk("overrun_set", overrun, 1);
        for (int n = 0; n < LEN + 20 && busy; n++) @(negedge clk);
        gap = 0;
        while (!busy && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        chk("b2b_gap", gap, 1);
        wait_idle();
        repeat (50) @(negedge clk);
        chk("overrun_sticky", overrun, 1);

        // run low blocks the start; raising it starts the pending angle
        @(negedge clk) run = 1'b0;
        tick_pulse();
        sc = 0;
        repeat (30) begin
            @(negedge clk);
            if (sclk || busy) sc++;
        end
        chk("run0_no_shift", sc, 0);
        @(negedge clk) run = 1'b1;
        @(negedge clk) chk("run1_start", busy, 1);
        wait_idle();

        // Asynchronous reset during a latched HIGH
        tick_pulse();
        found = 0;
        for (int n = 0; n < LEN + 10; n++) begin
            @(negedge clk);
            if (sclk && lat) begin found = 1; break; end
        end
        chk("lat_high_found", found, 1);
        #2 rst = 1'b0; model_on = 1'b0;
        #1;
        chk("rst_sclk", sclk, 0);
        chk("rst_lat", lat, 0);
        chk("rst_angle", angle, NA - 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_row", row, NC - 1);
        repeat (2) @(negedge clk);
        rst = 1'b1; model_on = 1'b1;
        start_angle();
        chk("post_rst_angle", angle, 0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            run        = ($urandom_range(0, 9) != 0);
            angle_tick = ($urandom_range(0, 119) == 0);
            swap_req   = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        model_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
